// File: rtl/xif_coproc_pkg.sv
// Shared types, field layout and width helpers for the XIF coprocessor multiplexer.
// The ID sits at bit 0 of issue requests and results; a commit is {id, kill}.
package xif_coproc_pkg;

  typedef logic [2:0] owner_idx_t;

  localparam int RESP_W          = 9;
  localparam int RESP_ACCEPT_BIT = 0;
  localparam int ISSUE_ID_LSB    = 0;
  localparam int RESULT_ID_LSB   = 0;
  localparam int COMMIT_KILL_BIT = 0;
  localparam int COMMIT_ID_LSB   = 1;

  localparam int ERR_MULTI_ACCEPT  = 2;
  localparam int ERR_ID_REUSE      = 1;
  localparam int ERR_ORPHAN_RESULT = 0;

  // Issue request: {rs_valid, rs, mode[1:0], instr[31:0], id}
  function automatic int issue_req_w(input int id_w, input int num_rs, input int rfr_w);
    return id_w + 32 + 2 + num_rs * rfr_w + num_rs;
  endfunction

  // Result: {exccode[5:0], exc, we, rd[4:0], data, id}
  function automatic int result_w(input int id_w, input int rfw_w);
    return id_w + rfw_w + 5 + 1 + 1 + 6;
  endfunction

endpackage

// File: rtl/xif_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority moves past the winner on advance.
module xif_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_o = '0;
    win     = '0;
    // Lowest requester overall is the wrap-around fallback; the lowest
    // requester at or above the pointer overrides it.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        win        = PTR_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (PTR_W'(i) >= ptr_q)) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        win        = PTR_W'(i);
      end
    end

    ptr_d = ptr_q;
    if (advance_i && |req_i) begin
      ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/xif_coproc_mux.sv
// Fans one CPU-side XIF out to NUM_COPROC coprocessors, tracking which channel
// owns each offload ID. Mem and compressed channels are tied off by the integrator.
module xif_coproc_mux
  import xif_coproc_pkg::*;
#(
  parameter  int NUM_COPROC  = 2,
  parameter  int X_ID_WIDTH  = 4,
  parameter  int X_NUM_RS    = 2,
  parameter  int X_RFR_WIDTH = 32,
  parameter  int X_RFW_WIDTH = 32,
  localparam int ISSUE_REQ_W = issue_req_w(X_ID_WIDTH, X_NUM_RS, X_RFR_WIDTH),
  localparam int RESULT_W    = result_w(X_ID_WIDTH, X_RFW_WIDTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,

  input  logic                           cpu_issue_valid_i,
  output logic                           cpu_issue_ready_o,
  input  logic [ISSUE_REQ_W-1:0]         cpu_issue_req_i,
  output logic [RESP_W-1:0]              cpu_issue_resp_o,

  input  logic                           cpu_commit_valid_i,
  input  logic [X_ID_WIDTH:0]            cpu_commit_i,

  output logic                           cpu_result_valid_o,
  input  logic                           cpu_result_ready_i,
  output logic [RESULT_W-1:0]            cpu_result_o,

  output logic [NUM_COPROC-1:0]          cp_issue_valid_o,
  input  logic [NUM_COPROC-1:0]          cp_issue_ready_i,
  output logic [ISSUE_REQ_W-1:0]         cp_issue_req_o,
  input  logic [NUM_COPROC*RESP_W-1:0]   cp_issue_resp_i,

  output logic [NUM_COPROC-1:0]          cp_commit_valid_o,
  output logic [X_ID_WIDTH:0]            cp_commit_o,

  input  logic [NUM_COPROC-1:0]          cp_result_valid_i,
  output logic [NUM_COPROC-1:0]          cp_result_ready_o,
  input  logic [NUM_COPROC*RESULT_W-1:0] cp_result_i,

  output logic [X_ID_WIDTH:0]            outstanding_o,
  output logic [2:0]                     err_o
);

  localparam int DEPTH = 2 ** X_ID_WIDTH;

  logic [DEPTH-1:0]    tbl_valid_q, tbl_valid_d;
  owner_idx_t          tbl_owner_q [DEPTH];
  owner_idx_t          tbl_owner_d [DEPTH];
  logic [X_ID_WIDTH:0] outstanding_q, outstanding_d;
  logic [2:0]          err_q, err_d;
  logic                buf_valid_q, buf_valid_d;
  logic [RESULT_W-1:0] buf_data_q, buf_data_d;

  // Issue path
  logic [NUM_COPROC-1:0] accept;
  logic                  issue_hs, set_en, multi_accept;
  owner_idx_t            set_owner;
  logic [X_ID_WIDTH-1:0] set_id;

  assign cp_issue_valid_o  = {NUM_COPROC{cpu_issue_valid_i}};
  assign cp_issue_req_o    = cpu_issue_req_i;
  assign cpu_issue_ready_o = &cp_issue_ready_i;
  assign issue_hs          = cpu_issue_valid_i & cpu_issue_ready_o;
  assign set_id            = cpu_issue_req_i[ISSUE_ID_LSB +: X_ID_WIDTH];

  always_comb begin
    accept           = '0;
    set_owner        = '0;
    cpu_issue_resp_o = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      accept[i] = cp_issue_resp_i[i*RESP_W + RESP_ACCEPT_BIT];
    end
    // Descending scan so the lowest accepting channel is written last.
    for (int i = NUM_COPROC - 1; i >= 0; i--) begin
      if (accept[i]) begin
        set_owner        = owner_idx_t'(i);
        cpu_issue_resp_o = cp_issue_resp_i[i*RESP_W +: RESP_W];
      end
    end
  end

  assign set_en       = issue_hs & (|accept);
  assign multi_accept = issue_hs & (|(accept & (accept - NUM_COPROC'(1))));

  // Commit path
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_hit, kill_clr;

  assign commit_id   = cpu_commit_i[COMMIT_ID_LSB +: X_ID_WIDTH];
  assign commit_hit  = cpu_commit_valid_i & tbl_valid_q[commit_id];
  assign kill_clr    = commit_hit & cpu_commit_i[COMMIT_KILL_BIT];
  assign cp_commit_o = cpu_commit_i;

  always_comb begin
    cp_commit_valid_o = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      cp_commit_valid_o[i] = commit_hit & (tbl_owner_q[commit_id] == owner_idx_t'(i));
    end
  end

  // Result path
  logic [NUM_COPROC-1:0] res_grant;
  owner_idx_t            res_owner;
  logic [RESULT_W-1:0]   res_data;
  logic [X_ID_WIDTH-1:0] res_id;
  logic                  res_load, res_match, res_clr, orphan;

  xif_rr_arb #(
    .NUM_REQ (NUM_COPROC)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (cp_result_valid_i),
    .advance_i (res_load),
    .grant_o   (res_grant)
  );

  always_comb begin
    res_owner = '0;
    res_data  = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (res_grant[i]) begin
        res_owner = owner_idx_t'(i);
        res_data  = cp_result_i[i*RESULT_W +: RESULT_W];
      end
    end
  end

  // No coprocessor handshake while in reset: the buffer is being flushed.
  assign res_load  = (|res_grant) & (~buf_valid_q | cpu_result_ready_i) & ~rst_i;
  assign res_id    = res_data[RESULT_ID_LSB +: X_ID_WIDTH];
  assign res_match = tbl_valid_q[res_id] & (tbl_owner_q[res_id] == res_owner);
  assign res_clr   = res_load & res_match;
  assign orphan    = res_load & ~res_match;

  assign cp_result_ready_o  = res_load ? res_grant : '0;
  assign cpu_result_valid_o = buf_valid_q & ~rst_i;
  assign cpu_result_o       = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (res_load) begin
      buf_valid_d = 1'b1;
      buf_data_d  = res_data;
    end else if (cpu_result_ready_i) begin
      buf_valid_d = 1'b0;
    end
  end

  // Ownership table, occupancy and sticky errors
  logic set_cleared;

  always_comb begin
    tbl_valid_d   = tbl_valid_q;
    tbl_owner_d   = tbl_owner_q;
    outstanding_d = '0;
    set_cleared   = (kill_clr & (commit_id == set_id)) | (res_clr & (res_id == set_id));

    for (int j = 0; j < DEPTH; j++) begin
      if ((kill_clr && commit_id == X_ID_WIDTH'(j)) || (res_clr && res_id == X_ID_WIDTH'(j))) begin
        tbl_valid_d[j] = 1'b0;
      end
      // A same-cycle set overrides any clear of the same id.
      if (set_en && set_id == X_ID_WIDTH'(j)) begin
        tbl_valid_d[j] = 1'b1;
        tbl_owner_d[j] = set_owner;
      end
    end

    for (int j = 0; j < DEPTH; j++) begin
      outstanding_d = outstanding_d + {{X_ID_WIDTH{1'b0}}, tbl_valid_d[j]};
    end

    err_d                    = err_q;
    err_d[ERR_MULTI_ACCEPT]  = err_q[ERR_MULTI_ACCEPT] | multi_accept;
    err_d[ERR_ID_REUSE]      = err_q[ERR_ID_REUSE] | (set_en & tbl_valid_q[set_id] & ~set_cleared);
    err_d[ERR_ORPHAN_RESULT] = err_q[ERR_ORPHAN_RESULT] | orphan;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tbl_valid_q   <= '0;
      outstanding_q <= '0;
      err_q         <= '0;
      buf_valid_q   <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        tbl_owner_q[j] <= '0;
      end
    end else begin
      tbl_valid_q   <= tbl_valid_d;
      tbl_owner_q   <= tbl_owner_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      buf_valid_q   <= buf_valid_d;
    end
  end

  // NOTE: the payload register is left out of reset; it is only observed
  // while buf_valid_q is set, so resetting it would cost muxes for nothing.
  always_ff @(posedge clk_i) begin
    buf_data_q <= buf_data_d;
  end

  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

// File: doc/xif_coproc_mux.md
XIF_COPROC_MUX -- requirements
Module: xif_coproc_mux

Interface
REQ-001 SHALL have parameter NUM_COPROC, default 2, range 1..8: number of coprocessor XIF channels.
REQ-002 SHALL have parameter X_ID_WIDTH, default 4: offload ID width; ownership table depth is 2**X_ID_WIDTH.
REQ-003 SHALL have parameters X_NUM_RS (default 2), X_RFR_WIDTH (default 32) and X_RFW_WIDTH (default 32): operand and result widths, as for the XIF.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have CPU-side issue ports: cpu_issue_valid_i (in, 1); cpu_issue_ready_o (out, 1); cpu_issue_req_i (in, ISSUE_REQ_W); cpu_issue_resp_o (out, 9).
REQ-007 SHALL have CPU-side commit ports: cpu_commit_valid_i (in, 1); cpu_commit_i (in, X_ID_WIDTH+1, fields {id, commit_kill}).
REQ-008 SHALL have CPU-side result ports: cpu_result_valid_o (out, 1); cpu_result_ready_i (in, 1); cpu_result_o (out, RESULT_W).
REQ-009 SHALL have coprocessor-side issue ports: cp_issue_valid_o (out, N); cp_issue_ready_i (in, N); cp_issue_resp_i (in, N*9).
REQ-010 SHALL have coprocessor-side commit ports: cp_commit_valid_o (out, N); cp_commit_o (out, X_ID_WIDTH+1, shared by all channels).
REQ-011 SHALL have coprocessor-side result ports: cp_result_valid_i (in, N); cp_result_ready_o (out, N); cp_result_i (in, N*RESULT_W).
REQ-012 SHALL have status ports: outstanding_o (out, X_ID_WIDTH+1): count of valid table entries; err_o (out, 3): sticky flags {multi_accept, id_reuse, orphan_result}.

Function
REQ-013 SHALL broadcast cpu_issue_valid_i and cpu_issue_req_i to every channel.
REQ-014 SHALL drive cpu_issue_ready_o = AND of cp_issue_ready_i; handshake = cpu_issue_valid_i & cpu_issue_ready_o.
REQ-015 SHALL drive cpu_issue_resp_o from the lowest-index channel with accept=1, or all-zero if no channel accepts (combinational).
REQ-016 SHALL, on handshake with accept, set table[id] = {valid, owner=winning index} at the next edge.
REQ-017 SHALL set err_o[2] when more than one channel accepts in the same handshake.
REQ-018 SHALL set err_o[1] when an accepted id is already valid and not freed in the same cycle.
REQ-019 SHALL assert cp_commit_valid_o[owner] only for commits whose id has a valid entry; commits to invalid ids SHALL be dropped silently.
REQ-020 SHALL pass cp_commit_o = cpu_commit_i combinationally.
REQ-021 SHALL clear the entry at the next edge when commit_kill=1.
REQ-022 SHALL grant a round-robin arbiter over cp_result_valid_i; after each grant, priority moves to winner+1 (mod N).
REQ-023 SHALL register results through a one-entry output buffer (latency 1 cycle).
REQ-024 SHALL load the buffer when it is empty or when cpu_result_ready_i=1 in that cycle, giving full throughput.
REQ-025 SHALL drive cp_result_ready_o one-hot: the granted channel only, and only when the buffer loads.
REQ-026 SHALL hold cpu_result_valid_o/cpu_result_o stable until cpu_result_ready_i.
REQ-027 SHALL clear table[id] on the cycle a result enters the buffer.
REQ-028 SHALL forward a result whose id is invalid or owned by another channel, and SHALL set err_o[0].
REQ-029 Same-cycle issue-set and result/kill-clear of the same id: the set SHALL win and no id_reuse error SHALL be raised.
REQ-030 Same-cycle kill and result on the same id: the entry SHALL be cleared once and outstanding_o SHALL decrement by 1.
REQ-031 SHALL update outstanding_o registered: +1 on set, -1 on clear, net 0 when both occur; it SHALL never wrap.
REQ-032 Mem and compressed channels are out of scope; the integrator SHALL tie them off.

Reset
REQ-033 On rst_i=1 at an edge, all table entries, the buffer valid, the RR pointer (to 0), outstanding_o and err_o SHALL reset to 0.
REQ-034 Reset asserted mid-transfer SHALL drop the buffered result, with no further handshake.
REQ-035 Combinational outputs SHALL follow their inputs during reset, except cpu_result_valid_o, which SHALL be 0.

Structure
REQ-036 Package xif_coproc_pkg SHALL hold owner_idx_t, ISSUE_REQ_W/RESULT_W width functions, field-offset constants and error-bit indices.
REQ-037 The round-robin arbiter SHALL be sub-module xif_rr_arb (NUM_REQ parameter, req/grant-onehot/advance ports).

Verification
REQ-038 N=2, both ready, cp1 accepts id=3 -> resp from cp1; table[3].owner=1; outstanding_o=1.
REQ-039 Commit id=3 kill=1 -> cp_commit_valid_o=2'b10; next cycle outstanding_o=0; a commit to id=5 (invalid) -> no cp_commit_valid_o.
REQ-040 cp0 and cp1 results valid continuously, cpu_result_ready_i=1 -> grants alternate 0,1,0,1; one result per cycle after 1-cycle latency.
REQ-041 cpu_result_ready_i=0 for 3 cycles -> output held stable; both cp_result_ready_o=0.
REQ-042 Both channels accept id=2 -> owner=0, err_o=3'b100; reissue of id=2 without freeing -> err_o=3'b110.
REQ-043 Reset asserted with the buffer full -> cpu_result_valid_o=0 next cycle; outstanding_o=0; RR restarts at channel 0.
